// File: rtl/pc_update_ctrl.sv
// PC-update sequencer: drives the PC-source select and the PC/EPC write enables,
// resolves branches from ALU flags and steps through multi-cycle exception entry.
module pc_update_ctrl #(
  parameter int MEM_LAT  = 2,
  parameter int VEC_BASE = 253
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seq_req,
  input  logic       br_req,
  input  logic [1:0] br_cond,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       j_req,
  input  logic       jr_req,
  input  logic       exc_req,
  input  logic [1:0] exc_cause,
  output logic [2:0] pc_source,
  output logic       pc_write,
  output logic       epc_write,
  output logic       exc_mem_read,
  output logic [7:0] exc_vec_addr,
  output logic       busy,
  output logic       taken,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, EXC_EPC, EXC_WAIT, EXC_LOAD} state_t;

  localparam logic [2:0] CNT_LAST   = 3'(MEM_LAT - 1);
  localparam logic [7:0] VEC_BASE_B = 8'(VEC_BASE);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] pc_source_q, pc_source_d;
  logic       pc_write_q, pc_write_d;
  logic       epc_write_q, epc_write_d;
  logic       mem_read_q, mem_read_d;
  logic [7:0] vec_addr_q, vec_addr_d;
  logic       busy_q, busy_d;
  logic       taken_q, taken_d;
  logic       done_q, done_d;

  function automatic logic branch_taken(input logic [1:0] cond, input logic z, input logic n);
    case (cond)
      2'b00:   return z;
      2'b01:   return !z;
      2'b10:   return n | z;
      default: return !n & !z;
    endcase
  endfunction

  // Reserved cause 11 shares the invalid-opcode vector.
  function automatic logic [7:0] vec_addr(input logic [1:0] cause);
    logic [1:0] c;
    c = (cause == 2'b11) ? 2'b00 : cause;
    return VEC_BASE_B + {6'd0, c};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_source_d = 3'd0;
    pc_write_d  = 1'b0;
    epc_write_d = 1'b0;
    mem_read_d  = 1'b0;
    vec_addr_d  = vec_addr_q;
    busy_d      = 1'b0;
    taken_d     = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_req) begin
          state_d     = EXC_EPC;
          epc_write_d = 1'b1;
          mem_read_d  = 1'b1;
          busy_d      = 1'b1;
          vec_addr_d  = vec_addr(exc_cause);
        end else if (jr_req) begin
          pc_source_d = 3'd3;
          pc_write_d  = 1'b1;
          done_d      = 1'b1;
        end else if (j_req) begin
          pc_source_d = 3'd2;
          pc_write_d  = 1'b1;
          done_d      = 1'b1;
        end else if (br_req) begin
          done_d = 1'b1;
          if (branch_taken(br_cond, alu_zero, alu_neg)) begin
            pc_source_d = 3'd1;
            pc_write_d  = 1'b1;
            taken_d     = 1'b1;
          end
        end else if (seq_req) begin
          pc_write_d = 1'b1;
          done_d     = 1'b1;
        end
      end
      EXC_EPC: begin
        state_d    = EXC_WAIT;
        cnt_d      = 3'd0;
        mem_read_d = 1'b1;
        busy_d     = 1'b1;
      end
      EXC_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = EXC_LOAD;
          pc_source_d = 3'd4;
          pc_write_d  = 1'b1;
          done_d      = 1'b1;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          mem_read_d = 1'b1;
        end
      end
      EXC_LOAD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      pc_source_q <= 3'd0;
      pc_write_q  <= 1'b0;
      epc_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      vec_addr_q  <= 8'd0;
      busy_q      <= 1'b0;
      taken_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_source_q <= pc_source_d;
      pc_write_q  <= pc_write_d;
      epc_write_q <= epc_write_d;
      mem_read_q  <= mem_read_d;
      vec_addr_q  <= vec_addr_d;
      busy_q      <= busy_d;
      taken_q     <= taken_d;
      done_q      <= done_d;
    end
  end

  assign pc_source    = pc_source_q;
  assign pc_write     = pc_write_q;
  assign epc_write    = epc_write_q;
  assign exc_mem_read = mem_read_q;
  assign exc_vec_addr = vec_addr_q;
  assign busy         = busy_q;
  assign taken        = taken_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Directed bench for pc_update_ctrl: fixed stimulus steps with hand-computed outputs.
module tb_pc_update_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       seq_req, br_req, j_req, jr_req, exc_req;
  logic [1:0] br_cond, exc_cause;
  logic       alu_zero, alu_neg;
  logic [2:0] pc_source;
  logic       pc_write, epc_write, exc_mem_read, busy, taken, done;
  logic [7:0] exc_vec_addr;

  int total = 0;
  int bad   = 0;

  pc_update_ctrl #(.MEM_LAT(2), .VEC_BASE(253)) dut (
    .clk(clk), .reset(reset),
    .seq_req(seq_req), .br_req(br_req), .br_cond(br_cond),
    .alu_zero(alu_zero), .alu_neg(alu_neg),
    .j_req(j_req), .jr_req(jr_req), .exc_req(exc_req), .exc_cause(exc_cause),
    .pc_source(pc_source), .pc_write(pc_write), .epc_write(epc_write),
    .exc_mem_read(exc_mem_read), .exc_vec_addr(exc_vec_addr),
    .busy(busy), .taken(taken), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    seq_req = 0; br_req = 0; j_req = 0; jr_req = 0; exc_req = 0;
    br_cond = 2'b00; exc_cause = 2'b00; alu_zero = 0; alu_neg = 0;
  endtask

  // Output vector order: src, pc_write, epc_write, mem_read, addr, busy, taken, done
  task automatic chk(input string tag, input logic [2:0] src, input logic pw, input logic ew,
                     input logic mr, input logic [7:0] addr, input logic bz,
                     input logic tk, input logic dn);
    logic [16:0] obs, exp;
    obs = {pc_source, pc_write, epc_write, exc_mem_read, exc_vec_addr, busy, taken, done};
    exp = {src, pw, ew, mr, addr, bz, tk, dn};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  initial begin
    clr();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("reset_state", 3'd0, 0, 0, 0, 8'd0, 0, 0, 0);

    seq_req = 1; tick(); clr();
    chk("seq", 3'd0, 1, 0, 0, 8'd0, 0, 0, 1);
    tick();
    chk("seq_after", 3'd0, 0, 0, 0, 8'd0, 0, 0, 0);

    br_req = 1; br_cond = 2'b00; alu_zero = 1; tick(); clr();
    chk("beq_taken", 3'd1, 1, 0, 0, 8'd0, 0, 1, 1);
    tick();
    chk("beq_after", 3'd0, 0, 0, 0, 8'd0, 0, 0, 0);

    br_req = 1; br_cond = 2'b00; alu_zero = 0; tick(); clr();
    chk("beq_not", 3'd0, 0, 0, 0, 8'd0, 0, 0, 1);

    br_req = 1; br_cond = 2'b01; alu_zero = 0; tick(); clr();
    chk("bne_taken", 3'd1, 1, 0, 0, 8'd0, 0, 1, 1);

    br_req = 1; br_cond = 2'b11; alu_neg = 1; tick(); clr();
    chk("bgt_not", 3'd0, 0, 0, 0, 8'd0, 0, 0, 1);

    br_req = 1; br_cond = 2'b10; alu_neg = 1; tick(); clr();
    chk("ble_taken", 3'd1, 1, 0, 0, 8'd0, 0, 1, 1);

    jr_req = 1; j_req = 1; seq_req = 1; tick(); clr();
    chk("prio_jr", 3'd3, 1, 0, 0, 8'd0, 0, 0, 1);

    j_req = 1; seq_req = 1; br_req = 1; tick(); clr();
    chk("prio_j", 3'd2, 1, 0, 0, 8'd0, 0, 0, 1);
    tick();
    chk("prio_after", 3'd0, 0, 0, 0, 8'd0, 0, 0, 0);

    // Exception, cause 01, MEM_LAT=2: vector at 254, PC load four edges later.
    exc_req = 1; exc_cause = 2'b01; jr_req = 1; tick(); clr();
    chk("exc1_epc", 3'd0, 0, 1, 1, 8'd254, 1, 0, 0);
    tick();
    chk("exc1_wait1", 3'd0, 0, 0, 1, 8'd254, 1, 0, 0);
    tick();
    chk("exc1_wait2", 3'd0, 0, 0, 1, 8'd254, 1, 0, 0);
    tick();
    chk("exc1_load", 3'd4, 1, 0, 0, 8'd254, 1, 0, 1);
    tick();
    chk("exc1_idle", 3'd0, 0, 0, 0, 8'd254, 0, 0, 0);

    // j_req during the wait is dropped.
    exc_req = 1; exc_cause = 2'b10; tick(); clr();
    chk("exc2_epc", 3'd0, 0, 1, 1, 8'd255, 1, 0, 0);
    tick();
    chk("exc2_wait1", 3'd0, 0, 0, 1, 8'd255, 1, 0, 0);
    j_req = 1; tick(); clr();
    chk("exc2_wait2_j", 3'd0, 0, 0, 1, 8'd255, 1, 0, 0);
    seq_req = 1; tick(); clr();
    chk("exc2_load", 3'd4, 1, 0, 0, 8'd255, 1, 0, 1);
    tick();
    chk("exc2_idle", 3'd0, 0, 0, 0, 8'd255, 0, 0, 0);

    // Cause 11 aliases to cause 0; reset during the wait abandons the entry.
    exc_req = 1; exc_cause = 2'b11; tick(); clr();
    chk("exc3_epc", 3'd0, 0, 1, 1, 8'd253, 1, 0, 0);
    tick();
    chk("exc3_wait1", 3'd0, 0, 0, 1, 8'd253, 1, 0, 0);
    reset = 1; tick(); reset = 0;
    chk("exc3_reset", 3'd0, 0, 0, 0, 8'd0, 0, 0, 0);
    tick();
    chk("exc3_no_load", 3'd0, 0, 0, 0, 8'd0, 0, 0, 0);
    seq_req = 1; tick(); clr();
    chk("post_reset_seq", 3'd0, 1, 0, 0, 8'd0, 0, 0, 1);
    tick();
    chk("post_reset_idle", 3'd0, 0, 0, 0, 8'd0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_update_ctrl.md
Name: pc_update_ctrl

Overview:
- Sequencer that owns the 5-way PC-source mux select and the PC/EPC write enables in the multicycle datapath.
- Accepts one-cycle next-PC requests from the main control FSM and resolves branch conditions from ALU flags.
- Runs the multi-cycle exception entry: EPC capture, vector byte read from memory, load of the handler address into PC.
- Sits between the main control unit and the PC register / PC-source mux / EPC register.

Parameters:
- MEM_LAT, 2, memory read latency in cycles for the exception vector byte (legal 1..7).
- VEC_BASE, 253, memory byte address of the first exception vector (cause 0).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seq_req  in  1  sequential update, PC <= PC+4 (mux input 0)
- br_req  in  1  conditional branch, target on mux input 1 (ALUOut)
- br_cond  in  2  00 beq, 01 bne, 10 ble, 11 bgt
- alu_zero  in  1  ALU zero flag, sampled with br_req
- alu_neg  in  1  ALU negative flag, sampled with br_req
- j_req  in  1  jump/jal, target on mux input 2
- jr_req  in  1  jump register, target on mux input 3
- exc_req  in  1  exception entry
- exc_cause  in  2  00 invalid opcode, 01 overflow, 10 divide by zero, 11 reserved (treated as 00)
- pc_source  out  3  PC-source mux select, values 0..4 only
- pc_write  out  1  PC register write enable, one-cycle pulse
- epc_write  out  1  EPC write enable, one-cycle pulse
- exc_mem_read  out  1  memory read request for the vector byte
- exc_vec_addr  out  8  vector byte address, VEC_BASE + cause
- busy  out  1  high while a request is in progress
- taken  out  1  pulses with pc_write on a taken branch
- done  out  1  one-cycle pulse when the request completes

Behaviour:
- All outputs registered. Reset values: pc_source=0, pc_write=0, epc_write=0, exc_mem_read=0, exc_vec_addr=0, busy=0, taken=0, done=0. FSM returns to IDLE.
- Reset has priority over every request, including in mid-exception. In-flight work is abandoned with no further pc_write/epc_write.
- States: IDLE, EXC_EPC, EXC_WAIT, EXC_LOAD.
- IDLE accepts requests only when not busy. If several requests are high in the same cycle, priority is exc > jr > j > br > seq; lower ones are dropped.
- Single-cycle requests: a request at edge N gives at edge N+1 pc_write=1, done=1, and pc_source set as follows:
  - seq_req: 0
  - jr_req: 3
  - j_req: 2
  - br_req: 1
- FSM stays in IDLE for single-cycle requests.
- Branch condition uses flags sampled at the request edge:
  - beq: zero
  - bne: !zero
  - ble: neg | zero
  - bgt: !neg & !zero
- Branch not taken: pc_write=0, taken=0, done=1, pc_source=0 (PC already advanced at fetch).
- Branch taken: taken=1 with pc_write.
- Exception sequence:
  - IDLE + exc_req: go to EXC_EPC. The cycle after the request has epc_write=1, busy=1, exc_mem_read=1, exc_vec_addr=VEC_BASE+cause (cause latched).
  - EXC_WAIT: exc_mem_read stays high. A counter runs MEM_LAT cycles. exc_vec_addr is held.
  - EXC_LOAD: pc_source=4, pc_write=1, done=1, exc_mem_read=0, then return to IDLE with busy=0 the next cycle.
  - Total latency from exc_req to pc_write: MEM_LAT+2 edges.
- busy is high from the cycle after exc_req up to and including the EXC_LOAD cycle. Any request while busy is ignored, not queued.
- pc_write, epc_write, done, taken are single-cycle pulses and are never high for two consecutive cycles from one request.
- pc_source returns to 0 the cycle after any pc_write.
- Select values 5..7 are never driven.
- Cause 11 maps to address VEC_BASE+0.

Test Plan:
- Reset, then seq_req pulse -> next cycle pc_source=0, pc_write=1, done=1; the following cycle all pulses 0.
- br_req with cond=00, zero=1 -> pc_source=1, pc_write=1, taken=1. Repeat with zero=0 -> pc_write=0, done=1, taken=0. Cover bgt with neg=1 (not taken) and ble with neg=1 (taken).
- jr_req, j_req and seq_req in the same cycle -> only pc_source=3, pc_write=1.
- exc_req with cause=01, MEM_LAT=2 -> the cycle after the request has epc_write=1 and exc_vec_addr=254. exc_mem_read stays high for 3 cycles. pc_write with pc_source=4 comes 4 edges after the request. busy is high for 4 cycles.
- j_req asserted during EXC_WAIT -> ignored: no extra pc_write, and the exception still completes with source 4.
- reset asserted in EXC_WAIT -> next cycle all outputs 0 and FSM in IDLE. A following seq_req completes normally one cycle later.
